// File: rtl/sll32_seq.sv
// ---------------------------------------------------------------------------
// sll32_seq : multi-cycle logical left shifter (sll / sllv)
//
// Shifts A left by a 5-bit amount. The amount comes from B[10:6] (sll,
// instruction shamt field) or B[4:0] (sllv, register operand). The shift runs
// at up to STEP bits per cycle, so the control FSM can stall on busy/done.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous reset, active-high, overrides start
//   start    in   1      request, taken only while not busy
//   var_sel  in   1      0: shamt=B[10:6]  1: shamt=B[4:0]
//   A        in   WIDTH  value to shift (sampled on accepted start)
//   B        in   WIDTH  shamt source (sampled on accepted start)
//   res      out  WIDTH  result register
//   busy     out  1      high while shifting
//   done     out  1      one-cycle pulse, res valid
//
// STEP must be 1, 2, 4 or 8. WIDTH must be at least 11 so B[10:6] exists.
// ---------------------------------------------------------------------------
module sll32_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             var_sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t           r_state;
  logic [4:0]       r_rem;
  logic [WIDTH-1:0] r_res;

  logic [4:0]       w_shamt;
  logic [4:0]       w_amt;
  logic [4:0]       w_rem_nxt;
  logic             w_unused;

  assign w_shamt   = var_sel ? B[4:0] : B[10:6];
  // Last iteration may need fewer than STEP bits.
  assign w_amt     = (r_rem < STEP5) ? r_rem : STEP5;
  assign w_rem_nxt = r_rem - w_amt;
  // Bits of B outside both shamt fields carry no meaning here.
  assign w_unused  = ^{B[WIDTH-1:11], B[5]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_res <= r_res << w_amt;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == 5'd0) r_state <= DONE;
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          if (start) begin
            r_res   <= A;
            r_rem   <= w_shamt;
            r_state <= (w_shamt != 5'd0) ? SHIFT : DONE;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Pure decodes of the state register: no path from start to busy/done.
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign res  = r_res;

endmodule

// File: tb/tb_sll32_seq.sv
module tb_sll32_seq;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic        var_sel = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] res1, res4;
  logic        busy1, busy4, done1, done4;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  exp_t q1[$], q4[$];

  sll32_seq #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .var_sel(var_sel), .A(A), .B(B),
    .res(res1), .busy(busy1), .done(done1));

  sll32_seq #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .var_sel(var_sel), .A(A), .B(B),
    .res(res4), .busy(busy4), .done(done4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumers: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) chk("u1_spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_res", res1, e.res);
        chk("u1_lat", 32'(cyc), 32'(e.cyc));
      end
    end
    if (!rst && done4) begin
      if (q4.size() == 0) chk("u4_spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("u4_res", res4, e.res);
        chk("u4_lat", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives a one-cycle start on unit `which` (1 or 4); pushes expectation if push.
  task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b,
                       input logic vs, input bit push, output int c);
    exp_t e;
    int   sh, n, step;
    step = which;
    sh = vs ? int'(b[4:0]) : int'(b[10:6]);
    n  = (sh + step - 1) / step;
    A = a; B = b; var_sel = vs;
    if (which == 1) start1 = 1'b1; else start4 = 1'b1;
    c = cyc;
    e.res = a << sh;
    e.cyc = c + n + 1;
    if (push) begin
      if (which == 1) q1.push_back(e); else q4.push_back(e);
    end
    tick();
    start1 = 1'b0; start4 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((q1.size() != 0 || q4.size() != 0) && k < budget) begin
      tick(); k++;
    end
    if (k >= budget) begin
      chk("timeout", 32'd1, 32'd0);
      q1.delete(); q4.delete();
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int c, d;
    logic [31:0] ra, rb;
    logic        rv;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_res1", res1, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_done1", {31'b0, done1}, 32'h0);
    chk("rst_res4", res4, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // T1 + T5: shamt 31 via B[10:6]; start ignored while busy; back-to-back in done cycle
    issue(1, 32'h1, 32'h7C0, 1'b0, 1'b1, c);
    @(negedge clk);
    chk("t1_busy_c1", {31'b0, busy1}, 32'h1);
    tick();
    wait_until(c + 5);
    issue(1, 32'hFFFF_FFFF, 32'h0000_001F, 1'b1, 1'b0, d);
    wait_until(c + 31);
    @(negedge clk);
    chk("t1_busy_c31", {31'b0, busy1}, 32'h1);
    tick();
    issue(1, 32'h1, 32'h1, 1'b1, 1'b1, d);  // cycle c+32 == T1 done cycle
    drain(100);
    tick();
    @(negedge clk);
    chk("t5_hold", res1, 32'h2);
    tick();

    // T2: sllv with upper B bits set
    issue(1, 32'hF000_000F, 32'hFFFF_F824, 1'b1, 1'b1, c);
    issue(4, 32'hF000_000F, 32'hFFFF_F824, 1'b1, 1'b1, c);
    drain(100);

    // T3: shamt 0, busy never rises
    issue(1, 32'h1234_5678, 32'hFFFF_F83F & ~32'h7C0, 1'b0, 1'b1, c);
    chk("t3_busy", {31'b0, busy1}, 32'h0);
    drain(100);
    tick();
    chk("t3_hold", res1, 32'h1234_5678);

    // T4: STEP=4, shamt 7 -> 2 shift cycles
    issue(4, 32'h3, 32'h7 << 6, 1'b0, 1'b1, c);
    drain(100);

    // T6: reset in cycle 10 of a shamt-31 operation
    issue(1, 32'h1, 32'h7C0, 1'b0, 1'b1, c);
    wait_until(c + 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    @(negedge clk);
    chk("t6_res", res1, 32'h0);
    chk("t6_busy", {31'b0, busy1}, 32'h0);
    chk("t6_done", {31'b0, done1}, 32'h0);
    repeat (40) tick();  // any done pulse here is flagged as spurious

    // Random operations on both units
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rv = 1'($urandom_range(0, 1));
      issue((i % 2 == 0) ? 1 : 4, ra, rb, rv, 1'b1, c);
      drain(100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
